// File: rtl/rom_load_pkg.sv
// Shared types and address map for the ROM download sequencer and any other
// loader that needs to split the flat HPS download space into ROM regions.
package rom_load_pkg;

  localparam int ADDR_W      = 25;
  localparam int ROM_ADDR_W  = 15;
  localparam int COUNT_W     = 18;
  localparam int NUM_REGIONS = 4;

  localparam logic [ADDR_W-1:0] CPU_BASE  = 25'h00000;
  localparam logic [ADDR_W-1:0] CPU_SIZE  = 25'h08000;
  localparam logic [ADDR_W-1:0] GFX_BASE  = 25'h08000;
  localparam logic [ADDR_W-1:0] GFX_SIZE  = 25'h08000;
  localparam logic [ADDR_W-1:0] SND_BASE  = 25'h10000;
  localparam logic [ADDR_W-1:0] SND_SIZE  = 25'h08000;
  localparam logic [ADDR_W-1:0] PROM_BASE = 25'h18000;
  localparam logic [ADDR_W-1:0] PROM_SIZE = 25'h00100;

  // Encodings 0..3 double as the bit index of the matching write strobe.
  typedef enum logic [2:0] {
    REGION_CPU  = 3'd0,
    REGION_GFX  = 3'd1,
    REGION_SND  = 3'd2,
    REGION_PROM = 3'd3,
    REGION_NONE = 3'd4
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  function automatic logic in_region(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] size);
    return (addr >= base) && (addr < (base + size));
  endfunction

endpackage

// File: rtl/rom_load_sequencer_decode.sv
// Combinational split of a flat download address into a ROM region and the
// address local to that region.
module rom_region_decode
  import rom_load_pkg::*;
(
  input  logic [ADDR_W-1:0]     addr,
  output region_e               region,
  output logic [ROM_ADDR_W-1:0] local_addr
);

  always_comb begin
    region     = REGION_NONE;
    local_addr = addr[ROM_ADDR_W-1:0];
    if (in_region(addr, CPU_BASE, CPU_SIZE)) begin
      region = REGION_CPU;
    end else if (in_region(addr, GFX_BASE, GFX_SIZE)) begin
      region = REGION_GFX;
    end else if (in_region(addr, SND_BASE, SND_SIZE)) begin
      region = REGION_SND;
    end else if (in_region(addr, PROM_BASE, PROM_SIZE)) begin
      // PROM is only 256 bytes deep, so the upper address bits are forced low.
      region     = REGION_PROM;
      local_addr = {{(ROM_ADDR_W-8){1'b0}}, addr[7:0]};
    end
  end

endmodule

// File: rtl/rom_load_sequencer.sv
// Routes HPS download bytes into the core ROM regions, counts them, checks the
// image size and keeps the core in reset while loading and for a short hold.
module rom_load_sequencer
  import rom_load_pkg::*;
#(
  parameter int unsigned EXPECTED_BYTES = 98560,
  parameter int unsigned HOLD_CYCLES    = 1024
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [ADDR_W-1:0]     ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic                  user_reset,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [7:0]            rom_data,
  output logic [3:0]            rom_we,
  output logic                  core_reset,
  output logic                  loaded,
  output logic                  bad_size,
  output logic [COUNT_W-1:0]    byte_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;
  localparam logic [COUNT_W-1:0] COUNT_GOOD = COUNT_W'(EXPECTED_BYTES);

  state_e                  state_reg, state_next;
  logic                    download_prev_reg;
  logic [HOLD_W-1:0]       hold_cnt_reg, hold_cnt_next;
  logic [COUNT_W-1:0]      byte_count_reg, byte_count_next;
  logic [3:0]              rom_we_reg, rom_we_next;
  logic [ROM_ADDR_W-1:0]   rom_addr_reg, rom_addr_next;
  logic [7:0]              rom_data_reg, rom_data_next;
  logic                    loaded_reg, loaded_next;
  logic                    bad_size_reg, bad_size_next;
  logic                    core_reset_reg, core_reset_next;

  logic                    dl_rise, dl_fall, wr_accept;
  logic [COUNT_W-1:0]      count_after;
  region_e                 region;
  logic [ROM_ADDR_W-1:0]   local_addr;
  logic [NUM_REGIONS-1:0]  region_onehot;

  rom_region_decode u_decode (
    .addr       (ioctl_addr),
    .region     (region),
    .local_addr (local_addr)
  );

  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_onehot
      assign region_onehot[gi] = (region == region_e'(3'(gi)));
    end
  endgenerate

  assign dl_rise   = ioctl_download & ~download_prev_reg;
  assign dl_fall   = ~ioctl_download & download_prev_reg;
  // Gating on state alone lets a write in the cycle download drops still land.
  assign wr_accept = (state_reg == ST_LOAD) & ioctl_wr;

  always_comb begin
    count_after = byte_count_reg;
    if (wr_accept && (byte_count_reg != COUNT_MAX)) begin
      count_after = byte_count_reg + 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    byte_count_next = count_after;
    loaded_next     = loaded_reg;
    bad_size_next   = bad_size_reg;
    rom_we_next     = wr_accept ? region_onehot : 4'b0000;
    rom_addr_next   = wr_accept ? local_addr : rom_addr_reg;
    rom_data_next   = wr_accept ? ioctl_dout : rom_data_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (dl_rise) begin
          state_next      = ST_LOAD;
          byte_count_next = '0;
          bad_size_next   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (dl_fall) begin
          state_next    = ST_HOLD;
          loaded_next   = 1'b1;
          bad_size_next = (count_after != COUNT_GOOD);
          hold_cnt_next = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (dl_rise) begin
          state_next      = ST_LOAD;
          byte_count_next = '0;
          bad_size_next   = 1'b0;
        end else if (user_reset) begin
          hold_cnt_next = HOLD_LOAD;
        end else if (hold_cnt_reg == '0) begin
          state_next = ST_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      ST_RUN: begin
        if (dl_rise) begin
          state_next      = ST_LOAD;
          byte_count_next = '0;
          bad_size_next   = 1'b0;
        end else if (user_reset) begin
          state_next    = ST_HOLD;
          hold_cnt_next = HOLD_LOAD;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    core_reset_next = (state_next != ST_RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      // Tracking the live level means a download already active at release is
      // not mistaken for a new one.
      download_prev_reg <= ioctl_download;
      hold_cnt_reg      <= '0;
      byte_count_reg    <= '0;
      rom_we_reg        <= 4'b0000;
      rom_addr_reg      <= '0;
      rom_data_reg      <= '0;
      loaded_reg        <= 1'b0;
      bad_size_reg      <= 1'b0;
      core_reset_reg    <= 1'b1;
    end else begin
      state_reg         <= state_next;
      download_prev_reg <= ioctl_download;
      hold_cnt_reg      <= hold_cnt_next;
      byte_count_reg    <= byte_count_next;
      rom_we_reg        <= rom_we_next;
      rom_addr_reg      <= rom_addr_next;
      rom_data_reg      <= rom_data_next;
      loaded_reg        <= loaded_next;
      bad_size_reg      <= bad_size_next;
      core_reset_reg    <= core_reset_next;
    end
  end

  assign rom_we     = rom_we_reg;
  assign rom_addr   = rom_addr_reg;
  assign rom_data   = rom_data_reg;
  assign core_reset = core_reset_reg;
  assign loaded     = loaded_reg;
  assign bad_size   = bad_size_reg;
  assign byte_count = byte_count_reg;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer: sparse images spread over all four
// regions, boundary addresses, user reset, stray writes and reset mid-load.
module tb_rom_load_sequencer;

  localparam int EXP_BYTES = 512;
  localparam int HOLD      = 1024;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_reset;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_we;
  logic        core_reset;
  logic        loaded;
  logic        bad_size;
  logic [17:0] byte_count;

  int n_checks  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (rom_we != 4'b0000) pulse_cnt <= pulse_cnt + 1;

  rom_load_sequencer #(
    .EXPECTED_BYTES (EXP_BYTES),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .user_reset     (user_reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_we         (rom_we),
    .core_reset     (core_reset),
    .loaded         (loaded),
    .bad_size       (bad_size),
    .byte_count     (byte_count)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Image layout: 128 bytes per region; CPU/GFX/SND at 256-byte stride, PROM at stride 2.
  function automatic logic [24:0] img_addr(input int i);
    int r = i / 128;
    int j = i % 128;
    if (r < 3) return 25'(r * 32'h8000 + j * 256);
    return 25'(32'h18000 + j * 2);
  endfunction

  function automatic logic [3:0] img_we(input int i);
    return 4'(1 << (i / 128));
  endfunction

  function automatic logic [14:0] img_local(input int i);
    if ((i / 128) < 3) return 15'((i % 128) * 256);
    return 15'((i % 128) * 2);
  endfunction

  task automatic wait_release(input int k0, input int exp_k, input string tag);
    int k = k0;
    while (core_reset === 1'b1 && k < 4000) begin
      tick();
      k++;
    end
    check_eq(tag, k, exp_k);
  endtask

  task automatic run_download(input int n, input bit fall_on_last, input bit exp_bad);
    int p0 = pulse_cnt;
    logic [24:0] a;
    ioctl_download = 1'b1;
    tick();
    check_eq("rise_core_reset", core_reset, 1'b1);
    check_eq("rise_count_clr", byte_count, 0);
    check_eq("rise_bad_clr", bad_size, 1'b0);
    for (int i = 0; i < n; i++) begin
      a = img_addr(i);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = a[7:0];
      if (fall_on_last && i == n - 1) ioctl_download = 1'b0;
      tick();
      ioctl_wr = 1'b0;
      check_eq("img_we", rom_we, img_we(i));
      check_eq("img_addr", rom_addr, img_local(i));
      check_eq("img_data", rom_data, a[7:0]);
    end
    if (!fall_on_last) ioctl_download = 1'b0;
    tick();
    check_eq("we_single", rom_we, 4'b0000);
    wait_release(fall_on_last ? 2 : 1, HOLD + 1, "dl_release");
    check_eq("pulse_count", pulse_cnt - p0, n);
    check_eq("byte_count", byte_count, n);
    check_eq("loaded", loaded, 1'b1);
    check_eq("bad_size", bad_size, exp_bad);
    $display("download %0d bytes (fall_on_last=%0b): byte_count=0x%0h loaded=%0b bad_size=%0b",
             n, fall_on_last, byte_count, loaded, bad_size);
  endtask

  logic [24:0] b_addr [5] = '{25'h07FFF, 25'h08000, 25'h17FFF, 25'h18000, 25'h18100};
  logic [3:0]  b_we   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic [14:0] b_loc  [5] = '{15'h7FFF, 15'h0000, 15'h7FFF, 15'h0000, 15'h0000};

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; user_reset = 1'b0;
    tick();
    tick();
    check_eq("rst_core_reset", core_reset, 1'b1);
    check_eq("rst_we", rom_we, 4'b0000);
    check_eq("rst_addr", rom_addr, 0);
    check_eq("rst_data", rom_data, 0);
    check_eq("rst_loaded", loaded, 1'b0);
    check_eq("rst_bad", bad_size, 1'b0);
    check_eq("rst_count", byte_count, 0);
    reset_n = 1'b1;
    tick();
    check_eq("idle_core_reset", core_reset, 1'b1);

    // Full-size image
    run_download(EXP_BYTES, 1'b0, 1'b0);

    // Boundary addresses
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = b_addr[i]; ioctl_dout = 8'hA0 + 8'(i);
      tick();
      ioctl_wr = 1'b0;
      check_eq("bnd_we", rom_we, b_we[i]);
      if (b_we[i] != 4'b0000) check_eq("bnd_addr", rom_addr, b_loc[i]);
      check_eq("bnd_count", byte_count, i + 1);
      $display("boundary write addr=0x%05h rom_we=%04b rom_addr=0x%04h byte_count=%0d",
               b_addr[i], rom_we, rom_addr, byte_count);
    end
    ioctl_download = 1'b0;
    wait_release(0, HOLD + 1, "bnd_release");
    check_eq("bnd_bad", bad_size, 1'b1);
    check_eq("bnd_loaded", loaded, 1'b1);

    // Short image, then a full image with the last write on the falling edge
    run_download(256, 1'b0, 1'b1);
    run_download(EXP_BYTES, 1'b1, 1'b0);

    // Stray write in RUN
    ioctl_wr = 1'b1; ioctl_addr = 25'h00100; ioctl_dout = 8'h55;
    tick();
    ioctl_wr = 1'b0;
    check_eq("stray_we", rom_we, 4'b0000);
    check_eq("stray_count", byte_count, EXP_BYTES);
    check_eq("stray_core_reset", core_reset, 1'b0);
    $display("stray write in RUN: rom_we=%04b byte_count=%0d", rom_we, byte_count);

    // User reset held 10 cycles
    user_reset = 1'b1;
    tick();
    check_eq("ureset_rise", core_reset, 1'b1);
    repeat (9) tick();
    user_reset = 1'b0;
    wait_release(0, HOLD, "ureset_release");
    $display("user reset: core_reset=%0b", core_reset);

    // Reset mid-download with a write pending in the reset cycle
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = img_addr(i); ioctl_dout = 8'h11;
      tick();
    end
    ioctl_addr = 25'h08123; ioctl_dout = 8'h77;
    reset_n = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    check_eq("mid_rst_we", rom_we, 4'b0000);
    check_eq("mid_rst_addr", rom_addr, 0);
    check_eq("mid_rst_data", rom_data, 0);
    check_eq("mid_rst_count", byte_count, 0);
    check_eq("mid_rst_loaded", loaded, 1'b0);
    check_eq("mid_rst_bad", bad_size, 1'b0);
    check_eq("mid_rst_core_reset", core_reset, 1'b1);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = img_addr(i);
      tick();
      ioctl_wr = 1'b0;
      check_eq("after_rst_we", rom_we, 4'b0000);
    end
    check_eq("after_rst_count", byte_count, 0);
    ioctl_download = 1'b0;
    repeat (3) tick();
    check_eq("after_rst_core_reset", core_reset, 1'b1);
    check_eq("after_rst_loaded", loaded, 1'b0);
    $display("reset mid-download: byte_count=%0d loaded=%0b core_reset=%0b",
             byte_count, loaded, core_reset);
    run_download(EXP_BYTES, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
